// File: rtl/ept_loop_pkg.sv
// Shared encodings for the loop counter bank: channel modes and per-channel FSM states.
package ept_loop_pkg;

    typedef enum logic [1:0] {
        MODE_WHILE   = 2'd0,
        MODE_REPEAT  = 2'd1,
        MODE_FOR     = 2'd2,
        MODE_COMPARE = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/ept_loop_channel.sv
// One loop channel: IDLE/RUN FSM with cycle counter, accumulator and registered outputs.
// EPT_LOOP_OVF_STICKY_EN adds a sticky FOR-mode carry flag (ovf).
module ept_loop_channel
    import ept_loop_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] MAX_COUNT  = 'hF0,
    parameter logic [DATA_W-1:0] REPEAT_MAX = 'h0A
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] limit,
    output logic              busy,
    output logic              done,
    output logic              pulse,
    output logic [DATA_W-1:0] result
`ifdef EPT_LOOP_OVF_STICKY_EN
    ,
    output logic              ovf
`endif
);

    // cnt runs one bit wider so REPEAT can count 2*lim cycles
    localparam int CW = DATA_W + 1;

    state_e            state, state_n;
    mode_e             mode_q;
    logic [CW-1:0]     cnt, tgt, tgt_d;
    logic [DATA_W-1:0] lim_q, lim_d, acc, wlim, rlim;
    logic              accept, at_tgt, finish, step;
    logic              busy_d, done_d, pulse_d;

    assign accept = (state == ST_IDLE) && start && !abort;
    assign at_tgt = (cnt == tgt);
    assign finish = (state == ST_RUN) && !abort && at_tgt;
    assign step   = (state == ST_RUN) && !abort && !at_tgt;

    assign wlim = (limit > MAX_COUNT)  ? MAX_COUNT  : limit;
    assign rlim = (limit > REPEAT_MAX) ? REPEAT_MAX : limit;

    // Completion target (in RUN cycles) and reported value, fixed at START
    always_comb begin
        tgt_d = '0;
        lim_d = '0;
        case (mode_e'(mode))
            MODE_WHILE:   begin tgt_d = {1'b0, wlim}; lim_d = wlim; end
            MODE_REPEAT:  begin tgt_d = {rlim, 1'b0}; lim_d = rlim; end
            MODE_FOR:     begin tgt_d = {1'b0, limit}; lim_d = limit; end
            MODE_COMPARE: begin tgt_d = '0; lim_d = (limit == MAX_COUNT) ? limit : '0; end
            default:      begin tgt_d = '0; lim_d = '0; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = ST_RUN;
            ST_RUN:  if (abort || at_tgt) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Pulses land on even RUN-cycle indices, so they appear every other cycle from t+2
    always_comb begin
        busy_d  = (state_n == ST_RUN);
        done_d  = finish;
        pulse_d = step && (mode_q == MODE_REPEAT) && !cnt[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            pulse  <= 1'b0;
            result <= '0;
        end else begin
            busy  <= busy_d;
            done  <= done_d;
            pulse <= pulse_d;
            if (finish) result <= (mode_q == MODE_FOR) ? acc : lim_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_WHILE;
            lim_q  <= '0;
            tgt    <= '0;
            cnt    <= '0;
            acc    <= '0;
        end else if (accept) begin
            mode_q <= mode_e'(mode);
            lim_q  <= lim_d;
            tgt    <= tgt_d;
            cnt    <= '0;
            acc    <= '0;
        end else if (step) begin
            cnt <= cnt + CW'(1);
            if (mode_q == MODE_FOR) acc <= acc + cnt[DATA_W-1:0];
        end
    end

`ifdef EPT_LOOP_OVF_STICKY_EN
    logic [DATA_W:0] sum;
    assign sum = {1'b0, acc} + {1'b0, cnt[DATA_W-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          ovf <= 1'b0;
        else if (accept)                                  ovf <= 1'b0;
        else if (step && mode_q == MODE_FOR && sum[DATA_W]) ovf <= 1'b1;
    end
`endif

endmodule

// File: rtl/ept_loop_counter_bank.sv
// Bank of NUM_CH independent loop channels sharing only clock and reset.
// EPT_LOOP_OVF_STICKY_EN adds the per-channel sticky FOR overflow output OVF.
module ept_loop_counter_bank
    import ept_loop_pkg::*;
#(
    parameter int                NUM_CH     = 4,
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] MAX_COUNT  = 'hF0,
    parameter logic [DATA_W-1:0] REPEAT_MAX = 'h0A
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_CH-1:0]        START,
    input  logic [NUM_CH-1:0]        ABORT,
    input  logic [2*NUM_CH-1:0]      MODE,
    input  logic [NUM_CH*DATA_W-1:0] LIMIT,
    output logic [NUM_CH-1:0]        BUSY,
    output logic [NUM_CH-1:0]        DONE,
    output logic [NUM_CH-1:0]        PULSE,
    output logic [NUM_CH*DATA_W-1:0] RESULT
`ifdef EPT_LOOP_OVF_STICKY_EN
    ,
    output logic [NUM_CH-1:0]        OVF
`endif
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ept_loop_channel #(
            .DATA_W     (DATA_W),
            .MAX_COUNT  (MAX_COUNT),
            .REPEAT_MAX (REPEAT_MAX)
        ) u_ch (
            .clk    (CLK),
            .rst    (RST),
            .start  (START[i]),
            .abort  (ABORT[i]),
            .mode   (MODE[2*i +: 2]),
            .limit  (LIMIT[i*DATA_W +: DATA_W]),
            .busy   (BUSY[i]),
            .done   (DONE[i]),
            .pulse  (PULSE[i]),
            .result (RESULT[i*DATA_W +: DATA_W])
`ifdef EPT_LOOP_OVF_STICKY_EN
            ,
            .ovf    (OVF[i])
`endif
        );
    end

endmodule

// File: tb/tb_ept_loop_counter_bank.sv
// Directed self-checking bench for ept_loop_counter_bank (4 ch, 8-bit); observes outputs at negedge.
// Build with EPT_LOOP_OVF_STICKY_EN to also check OVF.
module tb_ept_loop_counter_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  start = '0;
    logic [3:0]  abort = '0;
    logic [7:0]  mode = '0;
    logic [31:0] limit = '0;
    logic [3:0]  busy, done, pulse;
    logic [31:0] result;
`ifdef EPT_LOOP_OVF_STICKY_EN
    logic [3:0]  ovf;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ept_loop_counter_bank dut (
        .CLK    (clk),
        .RST    (rst),
        .START  (start),
        .ABORT  (abort),
        .MODE   (mode),
        .LIMIT  (limit),
        .BUSY   (busy),
        .DONE   (done),
        .PULSE  (pulse),
        .RESULT (result)
`ifdef EPT_LOOP_OVF_STICKY_EN
        ,
        .OVF    (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns in cycle t+1 (after edge t that sampled START); LIMIT is scrambled to prove capture
    task automatic start_ch(input int ch, input logic [1:0] m, input logic [7:0] l);
        @(negedge clk);
        start[ch] = 1'b1;
        mode[2*ch +: 2] = m;
        limit[8*ch +: 8] = l;
        @(posedge clk);
        #1;
        start[ch] = 1'b0;
        mode[2*ch +: 2] = ~m;
        limit[8*ch +: 8] = 8'h55;
        @(negedge clk);
    endtask

    task automatic run_one(input string tag, input int ch, input logic [1:0] m, input logic [7:0] l,
                           input int exp_lat, input logic [7:0] exp_res, input int exp_pulses);
        int k = 1;
        int np = 0;
        int bad = 0;
        start_ch(ch, m, l);
        check({tag, "_busy_t1"}, busy[ch], 1'b1);
        while (!done[ch] && k < 400) begin
            if (pulse[ch]) begin
                np++;
                if (k % 2 == 1) bad++;
            end
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, exp_lat);
        check({tag, "_result"}, result[8*ch +: 8], exp_res);
        check({tag, "_busy_at_done"}, busy[ch], 1'b0);
        check({tag, "_pulses"}, np, exp_pulses);
        check({tag, "_pulse_phase"}, bad, 0);
    endtask

    initial begin
        int k;
        int ndone;
        int lat [4];

        #12;
        check("reset_busy", busy, 4'h0);
        check("reset_done", done, 4'h0);
        check("reset_pulse", pulse, 4'h0);
        check("reset_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_one("while5",  0, 2'd0, 8'd5,   7,   8'd5,   0);
        run_one("while0",  0, 2'd0, 8'd0,   2,   8'd0,   0);
        run_one("whileFF", 0, 2'd0, 8'hFF,  242, 8'hF0,  0);
        run_one("rep3",    1, 2'd1, 8'd3,   8,   8'd3,   3);
        run_one("rep20",   1, 2'd1, 8'd20,  22,  8'h0A,  10);
        run_one("rep0",    1, 2'd1, 8'd0,   2,   8'd0,   0);
        run_one("for5",    2, 2'd2, 8'd5,   7,   8'd10,  0);
`ifdef EPT_LOOP_OVF_STICKY_EN
        check("for5_ovf", ovf[2], 1'b0);
`endif
        run_one("for32",   2, 2'd2, 8'h20,  34,  8'hF0,  0);
`ifdef EPT_LOOP_OVF_STICKY_EN
        check("for32_ovf", ovf[2], 1'b1);
        repeat (3) @(negedge clk);
        check("for32_ovf_sticky", ovf[2], 1'b1);
`endif
        run_one("cmpF0",   3, 2'd3, 8'hF0,  2,   8'hF0,  0);
        run_one("cmpEF",   3, 2'd3, 8'hEF,  2,   8'h00,  0);

        // Abort mid-run with an ignored restart at t+5; ch0 result stays F0
        run_one("pre_abort", 0, 2'd0, 8'hFF, 242, 8'hF0, 0);
        start_ch(0, 2'd0, 8'd100);
        k = 1;
        ndone = 0;
        while (k < 15) begin
            if (done[0]) ndone++;
            if (k == 10) check("abort_busy_t10", busy[0], 1'b1);
            if (k == 11) check("abort_busy_t11", busy[0], 1'b0);
            if (k == 5) begin
                start[0] = 1'b1;
                mode[1:0] = 2'd3;
                limit[7:0] = 8'hF0;
            end
            if (k == 10) abort[0] = 1'b1;
            @(posedge clk);
            #1;
            start[0] = 1'b0;
            abort[0] = 1'b0;
            @(negedge clk);
            k++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_result_kept", result[7:0], 8'hF0);

        // START with ABORT in IDLE must not launch
        @(negedge clk);
        start[1] = 1'b1;
        abort[1] = 1'b1;
        mode[3:2] = 2'd0;
        limit[15:8] = 8'd5;
        @(posedge clk);
        #1;
        start[1] = 1'b0;
        abort[1] = 1'b0;
        @(negedge clk);
        check("start_abort_idle", busy[1], 1'b0);

        // All channels on one edge
        @(negedge clk);
        start = 4'hF;
        mode = 8'b11_10_01_00;
        limit = {8'hEF, 8'd5, 8'd3, 8'd5};
        @(posedge clk);
        #1;
        start = 4'h0;
        limit = 32'h55555555;
        @(negedge clk);
        for (int c = 0; c < 4; c++) lat[c] = 0;
        for (int kk = 1; kk < 16; kk++) begin
            for (int c = 0; c < 4; c++) if (done[c] && lat[c] == 0) lat[c] = kk;
            @(negedge clk);
        end
        check("par_lat_ch0", lat[0], 7);
        check("par_lat_ch1", lat[1], 8);
        check("par_lat_ch2", lat[2], 7);
        check("par_lat_ch3", lat[3], 2);
        check("par_results", result, {8'h00, 8'd10, 8'd3, 8'd5});
`ifdef EPT_LOOP_OVF_STICKY_EN
        check("par_ovf_cleared", ovf[2], 1'b0);
`endif

        // Asynchronous reset mid-run
        start_ch(2, 2'd2, 8'h20);
        start_ch(1, 2'd1, 8'd10);
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 4'h0);
        check("rst_pulse", pulse, 4'h0);
        check("rst_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done != 4'h0) ndone++;
        end
        check("rst_no_done", ndone, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
